// File: rtl/display_timing_ctrl.sv
// ---------------------------------------------------------------------------
// display_timing_ctrl
// Raster timing generator for a parallel RGB display. Counts pixels per
// line (h) and lines per frame (v), produces active-low H/V syncs, data
// enable, frame-start pulse and RGB, all registered with one clock of
// latency, and pulls pixels from a source with a sticky underflow flag.
//
// Ports
//   iCLOCK          pixel clock
//   iRESET          asynchronous active-high reset
//   iENA            timing enable (low: counters and outputs held idle)
//   iPIXEL_VALID    source has a pixel this cycle
//   iPIXEL_DATA     {R,G,B} pixel from source
//   oPIXEL_REQ      combinational: pixel consumed this cycle if valid
//   onSYNC_H/V      active-low horizontal / vertical sync
//   oDISP_DE        active-area data enable
//   oDISP_R/G/B     pixel colour, zero outside the active area
//   oFRAME_START    one-cycle pulse at frame origin
//   oUNDERFLOW      sticky flag: active cycle without a valid pixel
//   iUNDERFLOW_CLR  clears oUNDERFLOW (a same-cycle set wins)
// ---------------------------------------------------------------------------
module display_timing_ctrl #(
    parameter int unsigned P_H_AREA = 640,
    parameter int unsigned P_V_AREA = 480,
    parameter int unsigned P_THP    = 95,
    parameter int unsigned P_THB    = 48,
    parameter int unsigned P_THF    = 15,
    parameter int unsigned P_TVP    = 2,
    parameter int unsigned P_TVB    = 33,
    parameter int unsigned P_TVF    = 10
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iENA,
    input  logic        iPIXEL_VALID,
    input  logic [23:0] iPIXEL_DATA,
    output logic        oPIXEL_REQ,
    output logic        onSYNC_H,
    output logic        onSYNC_V,
    output logic        oDISP_DE,
    output logic [7:0]  oDISP_R,
    output logic [7:0]  oDISP_G,
    output logic [7:0]  oDISP_B,
    output logic        oFRAME_START,
    output logic        oUNDERFLOW,
    input  logic        iUNDERFLOW_CLR
);

    localparam int unsigned HT     = P_THP + P_THB + P_H_AREA + P_THF;
    localparam int unsigned VT     = P_TVP + P_TVB + P_V_AREA + P_TVF;
    localparam int unsigned HW     = $clog2(HT);
    localparam int unsigned VW     = $clog2(VT);
    localparam int unsigned HA_BEG = P_THP + P_THB;
    localparam int unsigned HA_END = HA_BEG + P_H_AREA - 1;
    localparam int unsigned VA_BEG = P_TVP + P_TVB;
    localparam int unsigned VA_END = VA_BEG + P_V_AREA - 1;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_sync_h_n;
    logic          r_sync_v_n;
    logic          r_de;
    logic [23:0]   r_rgb;
    logic          r_frame_start;
    logic          r_underflow;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_hsync;
    logic          w_vsync;
    logic          w_active;
    logic          w_origin;
    logic [23:0]   w_pix;

    // Decode of the current raster position
    assign w_h_last = (r_h_cnt == HW'(HT - 1));
    assign w_v_last = (r_v_cnt == VW'(VT - 1));
    assign w_hsync  = (r_h_cnt < HW'(P_THP));
    assign w_vsync  = (r_v_cnt < VW'(P_TVP));
    assign w_active = (r_h_cnt >= HW'(HA_BEG)) && (r_h_cnt <= HW'(HA_END)) &&
                      (r_v_cnt >= VW'(VA_BEG)) && (r_v_cnt <= VW'(VA_END));
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    // Missing pixel in the active area shows as black
    assign w_pix    = iPIXEL_VALID ? iPIXEL_DATA : 24'h000000;

    // Pixel pull is combinational so the source sees it in the same cycle
    assign oPIXEL_REQ = iENA & w_active & ~iRESET;

    // Raster counters and registered, mutually aligned outputs
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_sync_h_n    <= 1'b1;
            r_sync_v_n    <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (!iENA) begin
            // Disabled: park at origin so re-enable starts a fresh frame
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_sync_h_n    <= 1'b1;
            r_sync_v_n    <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= 24'h000000;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
            r_sync_h_n    <= ~w_hsync;
            r_sync_v_n    <= ~w_vsync;
            r_de          <= w_active;
            r_rgb         <= w_active ? w_pix : 24'h000000;
            r_frame_start <= w_origin;
            // Set has priority over clear
            if (w_active && !iPIXEL_VALID) begin
                r_underflow <= 1'b1;
            end else if (iUNDERFLOW_CLR) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign onSYNC_H     = r_sync_h_n;
    assign onSYNC_V     = r_sync_v_n;
    assign oDISP_DE     = r_de;
    assign oDISP_R      = r_rgb[23:16];
    assign oDISP_G      = r_rgb[15:8];
    assign oDISP_B      = r_rgb[7:0];
    assign oFRAME_START = r_frame_start;
    assign oUNDERFLOW   = r_underflow;

endmodule
